// File: rtl/branch_predict_resolve_pkg.sv
// HighLevelControl: shared control-path types for the branch predict/resolve block.
//   pcSrc            : PC source select driven into the PC mux.
//   conditionalPCSrc : branch comparison type; 3'd7 is unencoded.
//   bhtCounter       : 2-bit saturating branch-history counter.
//   bht_train()      : saturating counter update.
package HighLevelControl;

    typedef enum logic [1:0] {
        PCp4_I    = 2'b00,
        Branch_C  = 2'b01,
        Jump_C    = 2'b10,
        JumpReg_C = 2'b11
    } pcSrc;

    typedef enum logic [2:0] {
        NO_BRANCH = 3'd0,
        BEQ       = 3'd1,
        BNE       = 3'd2,
        BLT       = 3'd3,
        BGE       = 3'd4,
        BLTU      = 3'd5,
        BGEU      = 3'd6
    } conditionalPCSrc;

    typedef logic [1:0] bhtCounter;

    localparam bhtCounter BHT_STRONG_NT = 2'b00;
    localparam bhtCounter BHT_WEAK_NT   = 2'b01;
    localparam bhtCounter BHT_WEAK_T    = 2'b10;
    localparam bhtCounter BHT_STRONG_T  = 2'b11;
    localparam bhtCounter BHT_RESET     = BHT_WEAK_NT;

    // Move one step toward the resolved direction, saturating at both ends.
    function automatic bhtCounter bht_train(input bhtCounter c, input logic taken);
        bhtCounter r;
        r = c;
        if (taken) begin
            if (c != BHT_STRONG_T) r = c + 2'd1;
        end else begin
            if (c != BHT_STRONG_NT) r = c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predict_resolve_condition_eval.sv
// branch_condition_eval: combinational branch resolution.
//   PCSrc_i, ConditionalPCSrc_i    : decoded PC source and branch type
//   Zero_i/Carry_i/Negative_i/oVerflow_i : ALU flags from the compare subtraction
//   PCSrcPostConditional_o         : resolved PC source
//   Taken_o                        : branch taken (0 for non-conditional)
//   IsConditional_o                : branch type is one of the six conditionals
module branch_condition_eval
    import HighLevelControl::*;
(
    input  pcSrc            PCSrc_i,
    input  conditionalPCSrc ConditionalPCSrc_i,
    input  logic            Zero_i,
    input  logic            Carry_i,
    input  logic            Negative_i,
    input  logic            oVerflow_i,
    output pcSrc            PCSrcPostConditional_o,
    output logic            Taken_o,
    output logic            IsConditional_o
);

    always_comb begin
        Taken_o         = 1'b0;
        IsConditional_o = 1'b1;
        case (ConditionalPCSrc_i)
            BEQ:     Taken_o = Zero_i;
            BNE:     Taken_o = ~Zero_i;
            BLT:     Taken_o = Negative_i ^ oVerflow_i;
            BGE:     Taken_o = ~(Negative_i ^ oVerflow_i);
            BLTU:    Taken_o = Carry_i;
            BGEU:    Taken_o = ~Carry_i;
            // NO_BRANCH and the unencoded value both fall through untouched
            default: IsConditional_o = 1'b0;
        endcase
    end

    always_comb begin
        PCSrcPostConditional_o = PCSrc_i;
        if (IsConditional_o)
            PCSrcPostConditional_o = Taken_o ? Branch_C : PCp4_I;
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: execute-stage branch resolver with a BHT of 2-bit
// saturating counters.
//   clk, reset            : clock, synchronous active-high reset
//   PC_F / PredictTaken_F : fetch PC and its combinational prediction
//   PC_C, Valid_C, PCSrc_C, ConditionalPCSrc_C, PredictedTaken_C, ALU flags :
//                           computational-stage instruction
//   PCSrcPostConditional_C, ActualTaken_C, Mispredict_C : resolution results
// Optional macro BRANCH_PERF_CNT_EN adds BranchCount / MispredictCount.
module branch_predict_resolve
    import HighLevelControl::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int BHT_IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_F,
    output logic            PredictTaken_F,
    input  logic [XLEN-1:0] PC_C,
    input  logic            Valid_C,
    input  pcSrc            PCSrc_C,
    input  conditionalPCSrc ConditionalPCSrc_C,
    input  logic            PredictedTaken_C,
    input  logic            Zero_C,
    input  logic            Carry_C,
    input  logic            Negative_C,
    input  logic            oVerflow_C,
    output pcSrc            PCSrcPostConditional_C,
    output logic            ActualTaken_C,
    output logic            Mispredict_C
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredictCount
`endif
);

    bhtCounter             bht_q [BHT_DEPTH];
    bhtCounter             bht_d;
    logic [BHT_IDX_W-1:0]  idx_f;
    logic [BHT_IDX_W-1:0]  idx_c;
    logic                  is_cond;
    logic                  taken;
    logic                  upd;

    // Word-aligned PCs: drop the byte offset, keep the low index bits.
    assign idx_f = PC_F[BHT_IDX_W+1:2];
    assign idx_c = PC_C[BHT_IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_F[XLEN-1:BHT_IDX_W+2], PC_F[1:0],
                              PC_C[XLEN-1:BHT_IDX_W+2], PC_C[1:0]};

    // Reads registered state only: an update this cycle is not bypassed.
    assign PredictTaken_F = bht_q[idx_f][1];

    branch_condition_eval u_eval (
        .PCSrc_i                (PCSrc_C),
        .ConditionalPCSrc_i     (ConditionalPCSrc_C),
        .Zero_i                 (Zero_C),
        .Carry_i                (Carry_C),
        .Negative_i             (Negative_C),
        .oVerflow_i             (oVerflow_C),
        .PCSrcPostConditional_o (PCSrcPostConditional_C),
        .Taken_o                (taken),
        .IsConditional_o        (is_cond)
    );

    assign ActualTaken_C = taken;
    assign upd           = Valid_C & is_cond;
    assign Mispredict_C  = upd & (taken != PredictedTaken_C);
    assign bht_d         = bht_train(bht_q[idx_c], taken);

    // Reset wins over a same-cycle training update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_RESET;
        end else if (upd) begin
            bht_q[idx_c] <= bht_d;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_q,  branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    assign branch_cnt_d  = branch_cnt_q  + {31'd0, upd};
    assign mispred_cnt_d = mispred_cnt_q + {31'd0, Mispredict_C};

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount     = branch_cnt_q;
    assign MispredictCount = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
module tb_branch_predict_resolve;
    import HighLevelControl::*;

    localparam int DEPTH = 64;

    logic            clk;
    logic            reset;
    logic [31:0]     PC_F, PC_C;
    logic            PredictTaken_F;
    logic            Valid_C, PredictedTaken_C;
    pcSrc            PCSrc_C, PCSrcPostConditional_C;
    conditionalPCSrc ConditionalPCSrc_C;
    logic            Zero_C, Carry_C, Negative_C, oVerflow_C;
    logic            ActualTaken_C, Mispredict_C;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0]     BranchCount, MispredictCount;
`endif

    branch_predict_resolve #(.XLEN(32), .BHT_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .PC_F                   (PC_F),
        .PredictTaken_F         (PredictTaken_F),
        .PC_C                   (PC_C),
        .Valid_C                (Valid_C),
        .PCSrc_C                (PCSrc_C),
        .ConditionalPCSrc_C     (ConditionalPCSrc_C),
        .PredictedTaken_C       (PredictedTaken_C),
        .Zero_C                 (Zero_C),
        .Carry_C                (Carry_C),
        .Negative_C             (Negative_C),
        .oVerflow_C             (oVerflow_C),
        .PCSrcPostConditional_C (PCSrcPostConditional_C),
        .ActualTaken_C          (ActualTaken_C),
        .Mispredict_C           (Mispredict_C)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .BranchCount            (BranchCount),
        .MispredictCount        (MispredictCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        pf;
        logic [1:0]  post;
        logic        at;
        logic        mp;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Reference state: one counter value 0..3 per table entry, plus event totals.
    int          mdl[DEPTH];
    int unsigned m_bc, m_mc;

    function automatic int ix(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    task automatic chk(input string nm, input string tag, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s [%s] got=%0d want=%0d @%0t", nm, tag, act, req, $time);
        end
    endtask

    // One stimulus cycle: drive at the falling edge, queue the expected response,
    // then advance the model to the state the next rising edge should produce.
    task automatic drive(input string tag, input logic [31:0] pcf, input logic [31:0] pcc,
                         input logic vld, input pcSrc ps, input conditionalPCSrc cs,
                         input logic pred, input logic z, input logic c, input logic n,
                         input logic v, input logic rst, input bit check);
        exp_t e;
        bit   cond, tk;
        @(negedge clk);
        reset = rst; PC_F = pcf; PC_C = pcc; Valid_C = vld; PCSrc_C = ps;
        ConditionalPCSrc_C = cs; PredictedTaken_C = pred;
        Zero_C = z; Carry_C = c; Negative_C = n; oVerflow_C = v;

        cond = 1'b1;
        case (int'(cs))
            1: tk = z;
            2: tk = !z;
            3: tk = (n != v);
            4: tk = (n == v);
            5: tk = c;
            6: tk = !c;
            default: begin tk = 1'b0; cond = 1'b0; end
        endcase
        e.tag  = tag;
        e.pf   = (mdl[ix(pcf)] >= 2);
        e.post = !cond ? ps : (tk ? Branch_C : PCp4_I);
        e.at   = tk;
        e.mp   = vld && cond && (tk != pred);
        e.bc   = m_bc;
        e.mc   = m_mc;
        if (check) sb.push_back(e);

        if (rst) begin
            foreach (mdl[i]) mdl[i] = 1;
            m_bc = 0; m_mc = 0;
        end else if (vld && cond) begin
            if (tk) mdl[ix(pcc)] = (mdl[ix(pcc)] == 3) ? 3 : mdl[ix(pcc)] + 1;
            else    mdl[ix(pcc)] = (mdl[ix(pcc)] == 0) ? 0 : mdl[ix(pcc)] - 1;
            m_bc++;
            if (tk != pred) m_mc++;
        end
    endtask

    // Monitor: the DUT presents a response every cycle; sample mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("PredictTaken_F", e.tag, PredictTaken_F, e.pf);
                chk("PCSrcPost",      e.tag, PCSrcPostConditional_C, e.post);
                chk("ActualTaken",    e.tag, ActualTaken_C, e.at);
                chk("Mispredict",     e.tag, Mispredict_C, e.mp);
`ifdef BRANCH_PERF_CNT_EN
                chk("BranchCount",    e.tag, BranchCount, e.bc);
                chk("MispredictCnt",  e.tag, MispredictCount, e.mc);
`endif
            end
        end
    end

    initial begin
        logic [2:0] rc;
        logic [1:0] rp;
        logic [31:0] pcc, pcf;
        foreach (mdl[i]) mdl[i] = 0;
        m_bc = 0; m_mc = 0;
        reset = 1'b1; PC_F = '0; PC_C = '0; Valid_C = 1'b0; PCSrc_C = PCp4_I;
        ConditionalPCSrc_C = NO_BRANCH; PredictedTaken_C = 1'b0;
        Zero_C = 1'b0; Carry_C = 1'b0; Negative_C = 1'b0; oVerflow_C = 1'b0;

        // Table contents are undefined until the first reset edge.
        drive("rst", 32'h0, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 1, 0);
        drive("rst", 32'h0, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 1, 0);

        // Every entry resets to weak-NT: reads 0, and one taken step flips it.
        drive("post_rst", 32'h100, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 0, 1);
        for (int i = 0; i <= DEPTH; i++)
            drive("sweep", 32'(i > 0 ? (i-1)*4 : 0), 32'(i*4), i < DEPTH, PCp4_I, BEQ,
                  0, 1,0,0,0, 0, 1);

        drive("rst2", 32'h0, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 1, 1);
        // Training BEQ taken: 01 -> 10 -> 11 -> 11
        for (int i = 0; i < 3; i++)
            drive("beq_train", 32'h100, 32'h100, 1, PCp4_I, BEQ, 0, 1,0,0,0, 0, 1);
        drive("beq_read", 32'h100, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 0, 1);
        // BNE not taken from 11: 10 then 01
        drive("bne1", 32'h100, 32'h100, 1, PCp4_I, BNE, 1, 1,0,0,0, 0, 1);
        drive("bne2", 32'h100, 32'h100, 1, PCp4_I, BNE, 1, 1,0,0,0, 0, 1);
        drive("bne_read", 32'h100, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 0, 1);
        // Correctly predicted signed/unsigned compares
        drive("blt",  32'h0, 32'h10, 1, PCp4_I, BLT,  1, 0,0,0,1, 0, 1);
        drive("bgeu", 32'h0, 32'h14, 1, PCp4_I, BGEU, 0, 0,1,0,0, 0, 1);
        drive("bltu", 32'h0, 32'h18, 1, PCp4_I, BLTU, 1, 0,1,0,0, 0, 1);
        // No-update cases, jump passthrough, unencoded type
        drive("inval", 32'h200, 32'h200, 0, PCp4_I, BEQ, 0, 1,0,0,0, 0, 1);
        drive("jump",  32'h200, 32'h200, 1, Jump_C, NO_BRANCH, 1, 1,0,0,0, 0, 1);
        drive("unenc", 32'h200, 32'h200, 1, JumpReg_C, conditionalPCSrc'(3'd7), 1, 1,0,0,0, 0, 1);
        drive("inval_rd", 32'h200, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 0, 1);
        // No bypass, aliasing, reset priority
        drive("nobyp", 32'h104, 32'h104, 1, PCp4_I, BEQ, 0, 1,0,0,0, 0, 1);
        drive("alias", 32'h204, 32'h204, 1, PCp4_I, BEQ, 0, 1,0,0,0, 0, 1);
        drive("alias_rd", 32'h104, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 0, 1);
        drive("rst_upd", 32'h104, 32'h104, 1, PCp4_I, BEQ, 0, 1,0,0,0, 1, 1);
        drive("rst_rd", 32'h104, 32'h104, 1, PCp4_I, BEQ, 0, 1,0,0,0, 0, 1);
        drive("rst_rd2", 32'h104, 32'h0, 0, PCp4_I, NO_BRANCH, 0, 0,0,0,0, 0, 1);

        // Randomized traffic over a few aliasing PC regions
        for (int k = 0; k < 3000; k++) begin
            rc  = 3'($urandom_range(0, 7));
            rp  = 2'($urandom_range(0, 3));
            pcc = ($urandom_range(0, 3) << 20) | $urandom_range(0, 1023);
            pcf = ($urandom_range(0, 3) == 0) ? pcc
                  : (($urandom_range(0, 3) << 20) | $urandom_range(0, 1023));
            drive("rand", pcf, pcc, 1'($urandom_range(0, 3) != 0), pcSrc'(rp),
                  conditionalPCSrc'(rc), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 99) == 0), 1);
        end

        @(negedge clk);
        #4;
        chk("sb_drained", "end", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Successor to the execute-stage branch condition resolver: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU from ALU flags and adds a parametrised branch history table (BHT) of 2-bit saturating counters.
- Fetch side: combinational taken/not-taken prediction indexed by PC.
- Computational side: resolves the branch, flags a mispredict against the prediction carried down the pipe, and trains the BHT on the next clock edge.
- Feeds PC-select and flush logic in the hazard unit.

Parameters:
- XLEN, 32, PC width in bits.
- BHT_DEPTH, 64, number of BHT entries; power of two, 2..1024.
- BHT_IDX_W, $clog2(BHT_DEPTH), derived index width; not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- PC_F  in  XLEN  fetch-stage PC.
- PredictTaken_F  out  1  prediction for PC_F.
- PC_C  in  XLEN  PC of the instruction in the computational stage.
- Valid_C  in  1  computational-stage instruction is real (not bubble/flushed/stalled-repeat).
- PCSrc_C  in  HighLevelControl::pcSrc  decoded PC source.
- ConditionalPCSrc_C  in  HighLevelControl::conditionalPCSrc  branch type.
- PredictedTaken_C  in  1  prediction made for this instruction at fetch, piped down.
- Zero_C, Carry_C, Negative_C, oVerflow_C  in  1 each  ALU flags from subtraction.
- PCSrcPostConditional_C  out  HighLevelControl::pcSrc  resolved PC source.
- ActualTaken_C  out  1  resolved branch direction.
- Mispredict_C  out  1  prediction wrong; hazard unit flushes F/D.

Behaviour:
- Index: idx(PC) = PC[BHT_IDX_W+1:2].
- PredictTaken_F = bht[idx(PC_F)][1]. Combinational, reads registered state only.
- Condition (combinational):
  - BEQ: Zero. BNE: ~Zero.
  - BLT: N^V. BGE: ~(N^V).
  - BLTU: Carry. BGEU: ~Carry.
- PCSrcPostConditional_C:
  - NO_BRANCH: PCSrc_C.
  - Conditional type: Branch_C if taken, else PCp4_I.
  - Unencoded value: PCSrc_C, no update, no mispredict.
- ActualTaken_C = 0 for non-conditional.
- Mispredict_C = Valid_C & conditional & (ActualTaken_C != PredictedTaken_C). Combinational, same cycle.
- BHT update on the rising edge when Valid_C & conditional, applied to bht[idx(PC_C)]:
  - Taken: counter +1, saturating at 2'b11.
  - Not taken: counter -1, saturating at 2'b00.
- Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- No update when Valid_C=0 or the instruction is not a conditional branch.
- Same-cycle fetch read of an index being updated returns the pre-update value; there is no bypass.
- Aliasing between PCs sharing an index is permitted and unhandled.
- Reset: every BHT entry becomes 2'b01 in the cycle reset is sampled high.
  - Reset takes priority over a simultaneous update.
  - Outputs are combinational from state/inputs, so PredictTaken_F = 0 after reset.
  - Reset mid-training discards all history.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined: adds output ports BranchCount  out  32 and MispredictCount  out  32.
  - BranchCount increments on every BHT update event.
  - MispredictCount increments when Mispredict_C is also high.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- HighLevelControl package:
  - existing pcSrc and conditionalPCSrc enums.
  - new typedef bhtCounter (logic [1:0]).
  - constants BHT_STRONG_NT/WEAK_NT/WEAK_T/STRONG_T and BHT_RESET = BHT_WEAK_NT.
- One sub-module, branch_condition_eval: pure combinational flag-to-taken evaluation plus the PCSrc mux.
- The BHT array, index logic and perf counters stay in the top module.

Test Plan:
1. Reset, then PC_F=0x100 → PredictTaken_F=0. Every index reads 01.
2. Three valid BEQ at PC_C=0x100, Zero=1, PredictedTaken_C=0 → cycle 1: Mispredict_C=1, Branch_C. After edges the counter reads 10, then 11, then stays 11; PredictTaken_F(0x100)=1 after the first edge.
3. From 11, BNE at 0x100 with Zero=1, PredictedTaken_C=1 → PCp4_I, Mispredict_C=1. Counter 10, prediction still 1. A second identical instance gives 01, prediction 0.
4. BLT with N=0,V=1 taken; BGEU with Carry=1 not taken; BLTU with Carry=1 taken. With PredictedTaken_C matching → Mispredict_C=0 each time.
5. Valid_C=0 BEQ at 0x200, and NO_BRANCH with PCSrc_C=jump → no counter change at 0x200, no mispredict. Jump is passed through.
6. BHT_DEPTH=64: update at PC_C=0x104 while PC_F=0x104 → same-cycle PredictTaken_F shows the old value, the next cycle shows the new value. PC 0x204 aliases to the same entry. Reset asserted together with an update → the entry is 01.
